snake_ctrl_scan: RTL and testbench

//  Parametrised snake-game controller: game FSM (INIT/RUN/STOP), direction FSM with

---
 rtl/snake_pkg.sv | 46 ++++
 rtl/snake_row_scanner.sv | 68 ++++++
 rtl/snake_ctrl_scan.sv | 187 ++++++++++++++++++
 tb/tb_snake_ctrl_scan.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake controller: state enums,
// button masks and the direction-reversal rule.
package snake_pkg;

    typedef enum logic [1:0] {
        GAME_INIT = 2'd0,
        GAME_RUN  = 2'd1,
        GAME_STOP = 2'd2
    } game_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        EXE_UPDATE     = 3'd0,
        EXE_CHECK      = 3'd1,
        EXE_INPUT      = 3'd2,
        EXE_WAIT_LOGIC = 3'd3,
        EXE_DISPLAY    = 3'd4
    } exec_e;

    // Button bus order is {RIGHT, LEFT, DOWN, UP}
    localparam logic [3:0] BTN_UP    = 4'b0001;
    localparam logic [3:0] BTN_DOWN  = 4'b0010;
    localparam logic [3:0] BTN_LEFT  = 4'b0100;
    localparam logic [3:0] BTN_RIGHT = 4'b1000;

    function automatic dir_e reverse_dir(input dir_e d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // Counter width for a 0..n-1 range, never below one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snake_row_scanner.sv
// Free-running multiplexed LED scanner: each row is held ROW_HOLD cycles,
// cathode/anode registered together, frame_end marks the last row's last cycle.
module snake_row_scanner
    import snake_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ROW_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [ROWS*COLS-1:0] led_flat_i,
    output logic [ROWS-1:0]      row_cathode_o,
    output logic [COLS-1:0]      column_anode_o,
    output logic                 frame_end_o
);

    localparam int HW = cnt_width(ROW_HOLD);
    localparam int RW = cnt_width(ROWS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ROW_HOLD - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    logic [HW-1:0]   hold_q, hold_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] cathode_q, cathode_d;
    logic [COLS-1:0] anode_q, anode_d;
    logic [COLS-1:0] led_rows [ROWS];
    logic            hold_wrap;
    logic            row_wrap;

    assign hold_wrap   = (hold_q == HOLD_LAST);
    assign row_wrap    = (row_q == ROW_LAST);
    assign frame_end_o = hold_wrap & row_wrap;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign led_rows[gi]  = led_flat_i[gi*COLS +: COLS];
            assign cathode_d[gi] = (row_q != RW'(gi));
        end
    endgenerate

    always_comb begin
        hold_d = hold_wrap ? '0 : hold_q + HW'(1);
        row_d  = row_q;
        if (hold_wrap) begin
            row_d = row_wrap ? '0 : row_q + RW'(1);
        end
        anode_d = led_rows[row_q];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hold_q    <= '0;
            row_q     <= '0;
            cathode_q <= '1;
            anode_q   <= '0;
        end else begin
            hold_q    <= hold_d;
            row_q     <= row_d;
            cathode_q <= cathode_d;
            anode_q   <= anode_d;
        end
    end

    assign row_cathode_o  = cathode_q;
    assign column_anode_o = anode_q;

endmodule

// File: rtl/snake_ctrl_scan.sv
// Snake game controller: game/direction/execution sequencing around the logic
// datapath handshake, plus the LED row scanner that paces display time.
module snake_ctrl_scan
    import snake_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int ROW_HOLD       = 4,
    parameter int DISPLAY_FRAMES = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                 clka,
    input  logic                 restart,
    input  logic [3:0]           direction_in,
    input  logic                 logic_done,
    input  logic                 game_end,
    input  logic [ROWS*COLS-1:0] led_flat,
    output logic [1:0]           game_state,
    output logic [1:0]           direction_state,
    output logic [2:0]           execution_state,
    output logic                 logic_tick,
    output logic                 no_update,
    output logic [ROWS-1:0]      row_cathode,
    output logic [COLS-1:0]      column_anode,
    output logic                 timeout_err
);

    localparam int WW = cnt_width(TIMEOUT);
    localparam int FW = cnt_width(DISPLAY_FRAMES);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(DISPLAY_FRAMES - 1);

    game_e         game_q, game_d;
    dir_e          dir_q, dir_d;
    exec_e         exec_q, exec_d;
    dir_e          pend_dir_q, pend_dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic          end_flag_q, end_flag_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          tick_q, tick_d;
    logic          no_update_q, no_update_d;

    logic          btn_valid;
    dir_e          btn_dir;
    logic          btn_accept;
    logic          frame_end;

    snake_row_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .ROW_HOLD (ROW_HOLD)
    ) u_scanner (
        .clk            (clka),
        .srst           (restart),
        .led_flat_i     (led_flat),
        .row_cathode_o  (row_cathode),
        .column_anode_o (column_anode),
        .frame_end_o    (frame_end)
    );

    // Only a clean single press counts; chords and idle are ignored
    always_comb begin
        btn_valid = 1'b1;
        btn_dir   = DIR_UP;
        case (direction_in)
            BTN_UP:    btn_dir = DIR_UP;
            BTN_DOWN:  btn_dir = DIR_DOWN;
            BTN_LEFT:  btn_dir = DIR_LEFT;
            BTN_RIGHT: btn_dir = DIR_RIGHT;
            default:   btn_valid = 1'b0;
        endcase
    end

    assign btn_accept = btn_valid && (btn_dir != reverse_dir(dir_q));

    always_ff @(posedge clka) begin
        if (restart) begin
            game_q       <= GAME_INIT;
            dir_q        <= DIR_RIGHT;
            exec_q       <= EXE_UPDATE;
            pend_dir_q   <= DIR_UP;
            pend_valid_q <= 1'b0;
            end_flag_q   <= 1'b0;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            tick_q       <= 1'b0;
            no_update_q  <= 1'b0;
        end else begin
            game_q       <= game_d;
            dir_q        <= dir_d;
            exec_q       <= exec_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            end_flag_q   <= end_flag_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            tick_q       <= tick_d;
            no_update_q  <= no_update_d;
        end
    end

    always_comb begin
        game_d       = game_q;
        dir_d        = dir_q;
        exec_d       = exec_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        end_flag_d   = end_flag_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
        frame_cnt_d  = frame_cnt_q;

        if (btn_accept) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = btn_dir;
        end

        case (exec_q)
            EXE_UPDATE: begin
                exec_d = EXE_CHECK;
                if (game_q == GAME_INIT && pend_valid_q) begin
                    game_d = GAME_RUN;
                end else if (game_q == GAME_RUN && end_flag_q) begin
                    game_d = GAME_STOP;
                end
            end
            EXE_CHECK: begin
                case (game_q)
                    GAME_INIT: exec_d = EXE_DISPLAY;
                    GAME_RUN:  exec_d = EXE_INPUT;
                    default:   exec_d = EXE_WAIT_LOGIC;
                endcase
            end
            EXE_INPUT: begin
                exec_d = EXE_WAIT_LOGIC;
                // A press landing this same cycle stays queued for the next tick
                if (pend_valid_q) begin
                    dir_d = pend_dir_q;
                    if (!btn_accept) begin
                        pend_valid_d = 1'b0;
                    end
                end
            end
            EXE_WAIT_LOGIC: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (logic_done) begin
                    end_flag_d = game_end;
                    exec_d     = EXE_DISPLAY;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d  = 1'b1;
                    exec_d     = EXE_DISPLAY;
                    wait_cnt_d = '0;
                end
            end
            EXE_DISPLAY: begin
                if (frame_end) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        exec_d      = EXE_UPDATE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
            end
            default: exec_d = EXE_UPDATE;
        endcase
    end

    // Handshake outputs are registered off the next state so they align with WAIT_LOGIC
    always_comb begin
        tick_d      = (exec_d == EXE_WAIT_LOGIC) && (exec_q != EXE_WAIT_LOGIC);
        no_update_d = (exec_d == EXE_WAIT_LOGIC) && (game_q == GAME_STOP);
    end

    assign game_state      = game_q;
    assign direction_state = dir_q;
    assign execution_state = exec_q;
    assign logic_tick      = tick_q;
    assign no_update       = no_update_q;
    assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_snake_ctrl_scan.sv
// Scoreboard bench for snake_ctrl_scan: expected tick records are queued as
// buttons are pressed and popped when the DUT raises logic_tick.
module tb_snake_ctrl_scan;
    import snake_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int ROW_HOLD = 4;
    localparam int DFRAMES = 4;
    localparam int TOUT = 255;

    logic                 clka = 1'b0;
    logic                 restart = 1'b1;
    logic [3:0]           direction_in = 4'b0000;
    logic                 logic_done = 1'b0;
    logic                 game_end = 1'b0;
    logic [ROWS*COLS-1:0] led_flat = 64'h8142_2418_1824_4281;
    logic [1:0]           game_state;
    logic [1:0]           direction_state;
    logic [2:0]           execution_state;
    logic                 logic_tick;
    logic                 no_update;
    logic [ROWS-1:0]      row_cathode;
    logic [COLS-1:0]      column_anode;
    logic                 timeout_err;

    always #5 clka = ~clka;

    snake_ctrl_scan #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .ROW_HOLD       (ROW_HOLD),
        .DISPLAY_FRAMES (DFRAMES),
        .TIMEOUT        (TOUT)
    ) dut (
        .clka            (clka),
        .restart         (restart),
        .direction_in    (direction_in),
        .logic_done      (logic_done),
        .game_end        (game_end),
        .led_flat        (led_flat),
        .game_state      (game_state),
        .direction_state (direction_state),
        .execution_state (execution_state),
        .logic_tick      (logic_tick),
        .no_update       (no_update),
        .row_cathode     (row_cathode),
        .column_anode    (column_anode),
        .timeout_err     (timeout_err)
    );

    typedef struct packed {
        logic       nu;
        logic [1:0] dir;
        logic [1:0] game;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic nu, input dir_e d, input game_e g);
        sb.push_back('{nu: nu, dir: d, game: g});
    endtask

    // Datapath responder: answers a tick after resp_delay cycles, or not at all
    logic resp_en = 1'b0;
    logic resp_end = 1'b0;
    int   resp_delay = 0;
    int   resp_cnt = -1;
    logic force_done = 1'b0;
    logic force_end = 1'b0;

    always @(negedge clka) begin
        if (restart) resp_cnt = -1;
        else if (logic_tick && resp_en) resp_cnt = resp_delay;
        logic_done = force_done;
        game_end   = force_done & force_end;
        if (resp_cnt == 0) begin
            logic_done = 1'b1;
            game_end   = resp_end;
        end
        if (resp_cnt >= 0) resp_cnt--;
    end

    // Scanner reference: edges since reset release and the LED word seen at that edge
    int                   n_edges = 0;
    logic [ROWS*COLS-1:0] led_prev;
    always @(posedge clka) begin
        if (restart) n_edges <= 0;
        else n_edges <= n_edges + 1;
        led_prev <= led_flat;
    end

    logic     armed = 1'b0;
    logic     prev_tick = 1'b0;
    logic     cur_nu = 1'b0;
    int       ticks_seen = 0;
    int       wait_run = 0;
    int       last_wait_len = 0;
    int       exp_row;
    logic [ROWS-1:0] exp_cath;
    exp_t     e;

    always @(negedge clka) begin
        if (armed) begin
            if (n_edges == 0) begin
                check_eq("rst_cathode", row_cathode, {ROWS{1'b1}});
                check_eq("rst_anode", column_anode, '0);
                check_eq("rst_game", game_state, GAME_INIT);
                check_eq("rst_dir", direction_state, DIR_RIGHT);
                check_eq("rst_exec", execution_state, EXE_UPDATE);
                check_eq("rst_tick", logic_tick, 1'b0);
                check_eq("rst_terr", timeout_err, 1'b0);
            end else begin
                exp_row  = ((n_edges - 1) / ROW_HOLD) % ROWS;
                exp_cath = {ROWS{1'b1}} ^ (ROWS'(1) << exp_row);
                check_eq("scan_cathode", row_cathode, exp_cath);
                check_eq("scan_anode", column_anode, led_prev[exp_row*COLS +: COLS]);
            end
            if (logic_tick) begin
                $display("[TB] tick @%0t game=%0d dir=%0d no_update=%0d", $time,
                         game_state, direction_state, no_update);
                check_eq("tick_width", prev_tick, 1'b0);
                check_eq("tick_in_wait", execution_state, EXE_WAIT_LOGIC);
                if (sb.size() == 0) begin
                    check_eq("tick_expected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("tick_no_update", no_update, e.nu);
                    check_eq("tick_dir", direction_state, e.dir);
                    check_eq("tick_game", game_state, e.game);
                    cur_nu = e.nu;
                end
                ticks_seen++;
            end
            prev_tick = logic_tick;
            if (execution_state == EXE_WAIT_LOGIC) begin
                check_eq("nu_hold", no_update, cur_nu);
                wait_run++;
            end else begin
                check_eq("nu_idle", no_update, 1'b0);
                if (wait_run > 0) last_wait_len = wait_run;
                wait_run = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clka); #1;
        restart = 1'b1;
        sb.delete();
        @(negedge clka); #1;
        restart = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        direction_in = b;
        @(negedge clka); #1;
        direction_in = 4'b0000;
    endtask

    task automatic wait_tick(input string tag, input int budget);
        int start = ticks_seen;
        for (int i = 0; i < budget; i++) begin
            @(negedge clka); #1;
            if (ticks_seen != start) break;
        end
        check_eq(tag, ticks_seen - start, 1);
    endtask

    task automatic wait_exec(input string tag, input exec_e st, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clka); #1;
            if (execution_state == st) break;
        end
        check_eq(tag, execution_state, st);
    endtask

    // One full game tick with the expected record queued first
    task automatic run_tick(input string tag, input logic nu, input dir_e d, input game_e g);
        push_exp(nu, d, g);
        wait_tick({tag, "_tick"}, 800);
        wait_exec({tag, "_disp"}, EXE_DISPLAY, 400);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clka);
        #1;
        armed   = 1'b1;
        restart = 1'b0;

        // Idle after reset: scanner runs, game stays in INIT, no ticks
        for (int i = 0; i < 100; i++) begin
            @(negedge clka); #1;
            if (i % 13 == 0) led_flat = {$urandom(), $urandom()};
        end
        check_eq("t1_game", game_state, GAME_INIT);
        check_eq("t1_ticks", ticks_seen, 0);
        check_eq("t1_terr", timeout_err, 1'b0);

        // First press starts the game and commits UP
        resp_en = 1'b1; resp_end = 1'b0; resp_delay = 0;
        press(BTN_UP);
        run_tick("t2", 1'b0, DIR_UP, GAME_RUN);
        check_eq("t2_dir", direction_state, DIR_UP);
        check_eq("t2_wait_len", last_wait_len, 1);

        // Reversal and multi-hot are dropped; last accepted press wins
        press(BTN_DOWN);
        press(4'b0011);
        run_tick("t3a", 1'b0, DIR_UP, GAME_RUN);
        press(BTN_LEFT);
        run_tick("t3b", 1'b0, DIR_LEFT, GAME_RUN);
        press(BTN_RIGHT);
        press(4'b1111);
        run_tick("t3c", 1'b0, DIR_LEFT, GAME_RUN);
        press(BTN_UP);
        press(BTN_DOWN);
        resp_delay = 3;
        run_tick("t3d", 1'b0, DIR_DOWN, GAME_RUN);
        check_eq("t3_wait_len", last_wait_len, 4);

        // Collision ends the game at the next UPDATE; STOP ticks only blink
        resp_end = 1'b1; resp_delay = 0;
        run_tick("t4a", 1'b0, DIR_DOWN, GAME_RUN);
        resp_end = 1'b0;
        check_eq("t4_game_pre", game_state, GAME_RUN);
        press(BTN_RIGHT);
        resp_delay = 5;
        run_tick("t4b", 1'b1, DIR_DOWN, GAME_STOP);
        check_eq("t4_wait_len", last_wait_len, 6);
        press(BTN_LEFT);
        resp_delay = 0;
        run_tick("t4c", 1'b1, DIR_DOWN, GAME_STOP);
        check_eq("t4_dir", direction_state, DIR_DOWN);
        check_eq("t4_game", game_state, GAME_STOP);

        // Silent datapath triggers the timeout, which stays set
        do_reset();
        press(BTN_UP);
        run_tick("t5a", 1'b0, DIR_UP, GAME_RUN);
        check_eq("t5_terr_pre", timeout_err, 1'b0);
        resp_en = 1'b0;
        run_tick("t5b", 1'b0, DIR_UP, GAME_RUN);
        check_eq("t5_wait_len", last_wait_len, TOUT);
        check_eq("t5_terr", timeout_err, 1'b1);
        force_end  = 1'b1;
        force_done = 1'b1;
        repeat (20) begin
            @(negedge clka); #1;
        end
        force_done = 1'b0;
        force_end  = 1'b0;
        resp_en = 1'b1;
        run_tick("t5c", 1'b0, DIR_UP, GAME_RUN);
        check_eq("t5_terr_sticky", timeout_err, 1'b1);
        check_eq("t5_game", game_state, GAME_RUN);

        // Restart mid-WAIT_LOGIC and mid-DISPLAY
        resp_en = 1'b0;
        push_exp(1'b0, DIR_UP, GAME_RUN);
        wait_tick("t6a_tick", 800);
        repeat (10) begin
            @(negedge clka); #1;
        end
        check_eq("t6a_in_wait", execution_state, EXE_WAIT_LOGIC);
        do_reset();
        check_eq("t6a_terr", timeout_err, 1'b0);
        check_eq("t6a_cath", row_cathode, {ROWS{1'b1}});
        resp_en = 1'b1;
        press(BTN_UP);
        run_tick("t6b", 1'b0, DIR_UP, GAME_RUN);
        repeat (7) begin
            @(negedge clka); #1;
        end
        do_reset();
        check_eq("t6b_game", game_state, GAME_INIT);
        check_eq("t6b_exec", execution_state, EXE_UPDATE);
        check_eq("t6b_dir", direction_state, DIR_RIGHT);
        repeat (40) begin
            @(negedge clka); #1;
        end
        check_eq("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
